// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between icache refill and
// dcache refill/writeback; one block transaction in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic [MASK_W-1:0] dc_wmask,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_data_valid,
    input  logic              mem_req_data_ready,
    output logic [DATA_W-1:0] mem_req_data_bits,
    output logic [MASK_W-1:0] mem_req_data_mask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              busy
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic G_IC = 1'b0;
    localparam logic G_DC = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WDATA,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_grant;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             w_win;
    logic             w_wbeat;

    // With both requesting, whoever was not served last wins.
    assign w_win   = (ic_req_valid && dc_req_valid) ? ~r_last_grant : dc_req_valid;
    assign w_wbeat = dc_wdata_valid && mem_req_data_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= G_IC;
            r_last_grant <= G_IC;
            r_beat_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (ic_req_valid || dc_req_valid)
                        r_grant <= w_win;
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_last_grant <= r_grant;
                        r_beat_cnt   <= '0;
                    end
                end
                S_WDATA: begin
                    if (w_wbeat)
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                end
                S_RESP: begin
                    if (mem_resp_valid)
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign ic_resp_data      = mem_resp_data;
    assign dc_resp_data      = mem_resp_data;
    assign mem_req_addr      = (r_grant == G_DC) ? dc_req_addr : ic_req_addr;
    assign mem_req_data_bits = dc_wdata;
    assign mem_req_data_mask = dc_wmask;
    assign busy              = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt        = r_state;
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        ic_resp_valid      = 1'b0;
        dc_resp_valid      = 1'b0;
        dc_wdata_ready     = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ic_req_valid || dc_req_valid)
                    w_state_nxt = S_REQ;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = (r_grant == G_DC) && dc_req_rw;
                ic_req_ready  = (r_grant == G_IC) && mem_req_ready;
                dc_req_ready  = (r_grant == G_DC) && mem_req_ready;
                if (mem_req_ready)
                    w_state_nxt = mem_req_rw ? S_WDATA : S_RESP;
            end
            S_WDATA: begin
                mem_req_data_valid = dc_wdata_valid;
                dc_wdata_ready     = mem_req_data_ready;
                if (w_wbeat && r_beat_cnt == LAST_BEAT)
                    w_state_nxt = S_IDLE;
            end
            S_RESP: begin
                ic_resp_valid = (r_grant == G_IC) && mem_resp_valid;
                dc_resp_valid = (r_grant == G_DC) && mem_resp_valid;
                if (mem_resp_valid && r_beat_cnt == LAST_BEAT)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts the
// round-robin winner, memory request fields, write-beat flow and response routing.
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;
    localparam int MASK_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ic_req_valid = 1'b0;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr = '0;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;
    logic              dc_req_valid = 1'b0;
    logic              dc_req_ready;
    logic              dc_req_rw = 1'b0;
    logic [ADDR_W-1:0] dc_req_addr = '0;
    logic              dc_wdata_valid = 1'b0;
    logic              dc_wdata_ready;
    logic [DATA_W-1:0] dc_wdata = '0;
    logic [MASK_W-1:0] dc_wmask = '0;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_data_valid;
    logic              mem_req_data_ready = 1'b0;
    logic [DATA_W-1:0] mem_req_data_bits;
    logic [MASK_W-1:0] mem_req_data_mask;
    logic              mem_resp_valid = 1'b0;
    logic [DATA_W-1:0] mem_resp_data = '0;
    logic              busy;

    int total = 0;
    int bad   = 0;
    bit m_last_dc = 1'b0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .MASK_W(MASK_W)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
        .dc_wdata(dc_wdata), .dc_wmask(dc_wmask), .dc_resp_valid(dc_resp_valid),
        .dc_resp_data(dc_resp_data), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One whole transaction. dir selects the fixed test-plan data patterns;
    // rst_after aborts a read with reset once that many beats have been delivered.
    task automatic run_txn(input bit ic_v, input bit dc_v, input bit rw, input int stall,
                           input logic [ADDR_W-1:0] ic_a, input logic [ADDR_W-1:0] dc_a,
                           input bit dir, input int rst_after);
        bit                win_dc;
        bit                exp_rw;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] d;
        logic [MASK_W-1:0] m;
        int                beats;
        int                guard;
        win_dc   = (ic_v && dc_v) ? !m_last_dc : dc_v;
        exp_rw   = win_dc && rw;
        exp_addr = win_dc ? dc_a : ic_a;

        @(negedge clk);
        ic_req_valid   = ic_v;
        ic_req_addr    = ic_a;
        dc_req_valid   = dc_v;
        dc_req_rw      = rw;
        dc_req_addr    = dc_a;
        mem_req_ready  = 1'b0;
        dc_wdata_valid = 1'b0;
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_resp_data  = rnd128();
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_mreq", mem_req_valid, 0);
        chk("idle_resp", {ic_resp_valid, dc_resp_valid}, 0);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            #1;
            chk("stall_mreq", mem_req_valid, 1);
            chk("stall_addr", mem_req_addr, exp_addr);
            chk("stall_rdy", {ic_req_ready, dc_req_ready}, 0);
        end

        @(negedge clk);
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        #1;
        chk("hs_mreq", mem_req_valid, 1);
        chk("hs_rdy", {ic_req_ready, dc_req_ready}, win_dc ? 2'b01 : 2'b10);
        chk("hs_addr", mem_req_addr, exp_addr);
        chk("hs_rw", mem_req_rw, exp_rw);
        m_last_dc = win_dc;

        beats = 0;
        guard = 0;
        while (beats < BEATS && guard < 60) begin
            @(negedge clk);
            guard++;
            mem_req_ready = 1'b0;
            if (win_dc) dc_req_valid = 1'b0;
            else        ic_req_valid = 1'b0;
            if (exp_rw) begin
                d = dir ? DATA_W'(8'h11 * (beats + 1)) : rnd128();
                m = dir ? '1 : MASK_W'($urandom);
                dc_wdata           = d;
                dc_wmask           = m;
                dc_wdata_valid     = (guard > 30) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                mem_req_data_ready = dir ? 1'(guard % 2) : ((guard > 30) ? 1'b1 : 1'($urandom_range(0, 1)));
                mem_resp_valid     = 1'($urandom_range(0, 1));
                #1;
                chk("w_dvalid", mem_req_data_valid, dc_wdata_valid);
                chk("w_dready", dc_wdata_ready, mem_req_data_ready);
                chk("w_bits", mem_req_data_bits, d);
                chk("w_mask", mem_req_data_mask, m);
                chk("w_noresp", {ic_resp_valid, dc_resp_valid}, 0);
                chk("w_busy", busy, 1);
                if (dc_wdata_valid && mem_req_data_ready) beats++;
            end else begin
                d = dir ? DATA_W'(8'hA0 + beats) : rnd128();
                mem_resp_data  = d;
                mem_resp_valid = (dir || guard > 30) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                #1;
                chk("r_icv", ic_resp_valid, !win_dc && mem_resp_valid);
                chk("r_dcv", dc_resp_valid, win_dc && mem_resp_valid);
                chk("r_data", win_dc ? dc_resp_data : ic_resp_data, d);
                chk("r_busy", busy, 1);
                if (mem_resp_valid) beats++;
                if (beats == rst_after) begin
                    @(negedge clk);
                    mem_resp_valid = 1'b1;
                    reset = 1'b1;
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_resp", {ic_resp_valid, dc_resp_valid}, 0);
                    chk("rst_req", {mem_req_valid, ic_req_ready, dc_req_ready, mem_req_rw}, 0);
                    @(negedge clk);
                    reset = 1'b0;
                    mem_resp_valid = 1'b0;
                    ic_req_valid = 1'b0;
                    dc_req_valid = 1'b0;
                    m_last_dc = 1'b0;
                    return;
                end
            end
        end
        if (beats < BEATS) chk("beat_timeout", beats, BEATS);

        @(negedge clk);
        ic_req_valid       = 1'b0;
        dc_req_valid       = 1'b0;
        dc_wdata_valid     = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'($urandom_range(0, 1));
        #1;
        chk("end_busy", busy, 0);
        chk("end_resp", {ic_resp_valid, dc_resp_valid}, 0);
        chk("end_dready", dc_wdata_ready, 0);
    endtask

    initial begin
        bit iv, dv;
        @(negedge clk);
        #1;
        chk("rst_state", {busy, mem_req_valid, ic_req_ready, dc_req_ready, mem_req_rw}, 0);
        chk("rst_outs", {ic_resp_valid, dc_resp_valid, dc_wdata_ready, mem_req_data_valid}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_txn(1, 1, 0, 0, 28'h0000300, 28'h0000400, 0, 99);
        run_txn(1, 1, 0, 1, 28'h0000301, 28'h0000401, 0, 99);
        run_txn(1, 1, 0, 0, 28'h0000302, 28'h0000402, 0, 99);
        run_txn(1, 0, 0, 0, 28'h0000100, 28'h0, 1, 99);
        run_txn(0, 1, 1, 0, 28'h0, 28'h0000200, 1, 99);
        run_txn(1, 0, 0, 5, 28'h0000500, 28'h0, 0, 99);
        run_txn(1, 0, 0, 0, 28'h0000600, 28'h0, 1, 2);
        run_txn(1, 0, 0, 0, 28'h0000601, 28'h0, 1, 99);
        run_txn(1, 1, 1, 0, 28'h0000700, 28'h0000701, 0, 99);

        for (int i = 0; i < 80; i++) begin
            iv = 1'($urandom_range(0, 1));
            dv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(iv, dv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    ADDR_W'($urandom), ADDR_W'($urandom), 0, 99);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
